// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, instruction memory request FSM,
// one-entry skid buffer for a response arriving during a stall, and the
// IF/ID pipeline register (instr, pc_plus4, valid).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state;
  state_t      stateNext;
  logic [31:0] pc;
  logic [31:0] pcInc;
  logic [31:0] skidInstr;
  logic [31:0] skidPcPlus4;
  logic        redirect;
  logic [31:0] redirectTarget;

  // Redirect decode: jump outranks branch; jump region comes from IF/ID pc_plus4
  always_comb begin
    redirect       = jump | branch;
    redirectTarget = jump ? {pc_plus4[31:28], jump_index, 2'b00} : branch_target;
    pcInc          = pc + 32'd4;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic: a redirect always restarts fetching at the target
  always_comb begin
    stateNext = state;
    if (redirect) begin
      stateNext = REQ;
    end else begin
      case (state)
        IDLE:    stateNext = REQ;
        REQ:     if (imem_ready && stall) stateNext = HOLD;
        HOLD:    if (!stall) stateNext = REQ;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Outputs: request only while actively fetching; address is always the PC
  always_comb begin
    imem_req  = (state == REQ);
    imem_addr = pc;
    opcode    = instr[31:26];
  end

  // PC, IF/ID register and skid buffer updates
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr       <= '0;
      pc_plus4    <= '0;
      valid       <= 1'b0;
      skidInstr   <= '0;
      skidPcPlus4 <= '0;
    end else if (redirect) begin
      pc          <= redirectTarget;
      valid       <= 1'b0;
      skidInstr   <= '0;
      skidPcPlus4 <= '0;
    end else begin
      case (state)
        REQ: begin
          if (imem_ready && !stall) begin
            instr    <= imem_rdata;
            pc_plus4 <= pcInc;
            valid    <= 1'b1;
            pc       <= pcInc;
          end else if (imem_ready && stall) begin
            // PC stays put; it advances when the skid word is released
            skidInstr   <= imem_rdata;
            skidPcPlus4 <= pcInc;
          end else if (!stall) begin
            valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr    <= skidInstr;
            pc_plus4 <= skidPcPlus4;
            valid    <= 1'b1;
            pc       <= pcInc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table followed by randomized
// stimulus compared against a behavioural model of the fetch stage.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_plus4;
  logic        valid;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .pc_plus4(pc_plus4), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stl, br, jmp, rdy;
    logic [31:0] rdata, tgt;
    logic [25:0] jidx;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expInstr, expPp4;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    logic [31:0] pp4;
  } skid_t;

  // Behavioural model: a word captured during a stall waits in a queue;
  // the fetcher is requesting whenever it is out of reset-idle and that
  // queue is empty.
  logic [31:0] mPc, mInstr, mPp4;
  logic        mValid;
  bit          mIdle;
  skid_t       skidQ[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, stl, br, jmp, rdy,
                              input logic [31:0] rdata, tgt, input logic [25:0] jidx,
                              input logic eReq, input logic [31:0] eAddr,
                              input logic eValid, input logic [31:0] eInstr, ePp4);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.jmp = jmp; v.rdy = rdy;
    v.rdata = rdata; v.tgt = tgt; v.jidx = jidx;
    v.expReq = eReq; v.expAddr = eAddr; v.expValid = eValid;
    v.expInstr = eInstr; v.expPp4 = ePp4;
    return v;
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic modelStep(input logic rst, stl, br, jmp, rdy,
                           input logic [31:0] rdata, tgt, input logic [25:0] jidx);
    skid_t s;
    if (rst) begin
      mPc = 32'h0; mInstr = 32'h0; mPp4 = 32'h0; mValid = 1'b0;
      mIdle = 1'b1; skidQ.delete();
    end else if (jmp || br) begin
      mPc    = jmp ? ((mPp4 & 32'hF000_0000) | ({6'b0, jidx} << 2)) : tgt;
      mValid = 1'b0;
      mIdle  = 1'b0;
      skidQ.delete();
    end else if (mIdle) begin
      mIdle = 1'b0;
    end else if (skidQ.size() != 0) begin
      if (!stl) begin
        s = skidQ.pop_front();
        mInstr = s.w; mPp4 = s.pp4; mValid = 1'b1;
        mPc = mPc + 32'd4;
      end
    end else if (rdy) begin
      if (stl) begin
        s.w = rdata; s.pp4 = mPc + 32'd4;
        skidQ.push_back(s);
      end else begin
        mInstr = rdata; mPp4 = mPc + 32'd4; mValid = 1'b1;
        mPc = mPc + 32'd4;
      end
    end else if (!stl) begin
      mValid = 1'b0;
    end
  endtask

  task automatic drive(input logic rst, stl, br, jmp, rdy,
                       input logic [31:0] rdata, tgt, input logic [25:0] jidx);
    reset = rst; stall = stl; branch = br; jump = jmp; imem_ready = rdy;
    imem_rdata = rdata; branch_target = tgt; jump_index = jidx;
  endtask

  vec_t vecs[23];

  initial begin
    logic [31:0] expI;
    logic        rRst, rStl, rBr, rJmp, rRdy;
    logic [31:0] rData, rTgt;
    logic [25:0] rJidx;

    // rst stl br jmp rdy  rdata  tgt  jidx | req addr valid instr pp4
    vecs[0]  = mk(1,0,0,0,0, 32'h0,         32'h0,         26'h0,  0, 32'h0,         0, 32'h0,         32'h0);
    vecs[1]  = mk(0,0,0,0,1, 32'hDEAD_BEEF, 32'h0,         26'h0,  1, 32'h0,         0, 32'h0,         32'h0);
    vecs[2]  = mk(0,0,0,0,1, 32'h2001_0005, 32'h0,         26'h0,  1, 32'h4,         1, 32'h2001_0005, 32'h4);
    vecs[3]  = mk(0,0,0,0,1, 32'h0022_1820, 32'h0,         26'h0,  1, 32'h8,         1, 32'h0022_1820, 32'h8);
    vecs[4]  = mk(0,1,0,0,1, 32'h1111_1111, 32'h0,         26'h0,  0, 32'h8,         1, 32'h0022_1820, 32'h8);
    vecs[5]  = mk(0,1,0,0,1, 32'hBAD0_0001, 32'h0,         26'h0,  0, 32'h8,         1, 32'h0022_1820, 32'h8);
    vecs[6]  = mk(0,1,0,0,1, 32'hBAD0_0002, 32'h0,         26'h0,  0, 32'h8,         1, 32'h0022_1820, 32'h8);
    vecs[7]  = mk(0,0,0,0,1, 32'hBAD0_0003, 32'h0,         26'h0,  1, 32'hC,         1, 32'h1111_1111, 32'hC);
    vecs[8]  = mk(0,0,0,0,1, 32'h2222_2222, 32'h0,         26'h0,  1, 32'h10,        1, 32'h2222_2222, 32'h10);
    vecs[9]  = mk(0,0,0,1,1, 32'hBAD0_0004, 32'h0,         26'h40, 1, 32'h100,       0, 32'h2222_2222, 32'h10);
    vecs[10] = mk(0,0,0,0,1, 32'h3333_3333, 32'h0,         26'h0,  1, 32'h104,       1, 32'h3333_3333, 32'h104);
    vecs[11] = mk(0,1,1,0,1, 32'hBAD0_0005, 32'h200,       26'h0,  1, 32'h200,       0, 32'h3333_3333, 32'h104);
    vecs[12] = mk(0,0,0,0,0, 32'hBAD0_0006, 32'h0,         26'h0,  1, 32'h200,       0, 32'h3333_3333, 32'h104);
    vecs[13] = mk(0,0,0,0,0, 32'hBAD0_0007, 32'h0,         26'h0,  1, 32'h200,       0, 32'h3333_3333, 32'h104);
    vecs[14] = mk(0,0,0,0,1, 32'h4444_4444, 32'h0,         26'h0,  1, 32'h204,       1, 32'h4444_4444, 32'h204);
    vecs[15] = mk(0,0,1,0,1, 32'hBAD0_0008, 32'hFFFF_FFFC, 26'h0,  1, 32'hFFFF_FFFC, 0, 32'h4444_4444, 32'h204);
    vecs[16] = mk(0,0,0,0,1, 32'h5555_5555, 32'h0,         26'h0,  1, 32'h0,         1, 32'h5555_5555, 32'h0);
    vecs[17] = mk(0,1,0,0,1, 32'h6666_6666, 32'h0,         26'h0,  0, 32'h0,         1, 32'h5555_5555, 32'h0);
    vecs[18] = mk(1,0,0,0,1, 32'hBAD0_0009, 32'h0,         26'h0,  0, 32'h0,         0, 32'h0,         32'h0);
    vecs[19] = mk(0,0,0,0,1, 32'hBAD0_000A, 32'h0,         26'h0,  1, 32'h0,         0, 32'h0,         32'h0);
    vecs[20] = mk(0,0,0,0,1, 32'h7777_7777, 32'h0,         26'h0,  1, 32'h4,         1, 32'h7777_7777, 32'h4);
    vecs[21] = mk(0,0,1,1,1, 32'hBAD0_000B, 32'h200,       26'h3,  1, 32'hC,         0, 32'h7777_7777, 32'h4);
    vecs[22] = mk(0,0,0,0,1, 32'h8888_8888, 32'h0,         26'h0,  1, 32'h10,        1, 32'h8888_8888, 32'h10);

    drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 26'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].jmp, vecs[i].rdy,
            vecs[i].rdata, vecs[i].tgt, vecs[i].jidx);
      @(posedge clk);
      #1;
      expI = vecs[i].expInstr;
      check($sformatf("vec%0d.imem_req", i),  {31'b0, imem_req}, {31'b0, vecs[i].expReq});
      check($sformatf("vec%0d.imem_addr", i), imem_addr,         vecs[i].expAddr);
      check($sformatf("vec%0d.valid", i),     {31'b0, valid},    {31'b0, vecs[i].expValid});
      check($sformatf("vec%0d.instr", i),     instr,             vecs[i].expInstr);
      check($sformatf("vec%0d.pc_plus4", i),  pc_plus4,          vecs[i].expPp4);
      check($sformatf("vec%0d.opcode", i),    {26'b0, opcode},   {26'b0, expI[31:26]});
    end

    // Randomized phase; first cycle is a reset so the model starts aligned
    for (int c = 0; c < 3000; c++) begin
      rRst  = (c == 0) || ($urandom_range(0, 99) == 0);
      rJmp  = ($urandom_range(0, 15) == 0);
      rBr   = ($urandom_range(0, 15) == 0);
      rStl  = ($urandom_range(0, 3) == 0);
      rRdy  = ($urandom_range(0, 3) != 0);
      rTgt  = {$urandom(), 2'b00} >> 0;
      rTgt[1:0] = 2'b00;
      rJidx = 26'($urandom());
      rData = rRdy ? memWord(mPc) : $urandom();
      drive(rRst, rStl, rBr, rJmp, rRdy, rData, rTgt, rJidx);
      @(posedge clk);
      modelStep(rRst, rStl, rBr, rJmp, rRdy, rData, rTgt, rJidx);
      #1;
      check($sformatf("rnd%0d.imem_req", c),  {31'b0, imem_req},
            {31'b0, (!mIdle && skidQ.size() == 0)});
      check($sformatf("rnd%0d.imem_addr", c), imem_addr, mPc);
      check($sformatf("rnd%0d.valid", c),     {31'b0, valid}, {31'b0, mValid});
      check($sformatf("rnd%0d.instr", c),     instr, mInstr);
      check($sformatf("rnd%0d.pc_plus4", c),  pc_plus4, mPp4);
      check($sformatf("rnd%0d.opcode", c),    {26'b0, opcode}, {26'b0, mInstr[31:26]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 stall  input  1  hold PC and IF/ID outputs.
REQ-006 branch  input  1  redirect to branch_target; qualified branch from the decode stage.
REQ-007 branch_target  input  32  branch destination.
REQ-008 jump  input  1  redirect to the jump address.
REQ-009 jump_index  input  26  instr_index field of the jump in decode.
REQ-010 imem_req  output  1  instruction memory read request.
REQ-011 imem_addr  output  32  instruction memory word address (byte address, [1:0]=00).
REQ-012 imem_ready  input  1  imem_rdata valid this cycle.
REQ-013 imem_rdata  input  32  fetched instruction.
REQ-014 instr  output  32  IF/ID instruction register.
REQ-015 opcode  output  6  instr[31:26], fed to the control unit.
REQ-016 pc_plus4  output  32  IF/ID PC+4 of instr.
REQ-017 valid  output  1  instr holds a live instruction.

Function
REQ-018 The FSM SHALL have three states: IDLE, REQ and HOLD.
REQ-019 IDLE SHALL keep imem_req=0 and SHALL move to REQ on the next cycle.
REQ-020 REQ SHALL drive imem_req=1 and imem_addr=pc.
- imem_ready=1, stall=0: load instr<=imem_rdata, pc_plus4<=pc+4, valid<=1, pc<=next_pc, stay in REQ.
- imem_ready=1, stall=1: capture imem_rdata and pc+4 into the skid buffer, hold IF/ID, go to HOLD.
- imem_ready=0, stall=0: valid<=0, pc held.
- imem_ready=0, stall=1: IF/ID held, including valid.
REQ-021 HOLD SHALL drive imem_req=0.
- While stall=1: IF/ID and PC held.
- When stall=0: load IF/ID from the skid buffer, set valid=1, set pc<=pc+4, return to REQ.
REQ-022 next_pc in REQ SHALL be pc+4 with 32-bit wrap-around (32'hFFFF_FFFC+4 = 0).
REQ-023 Redirect priority SHALL be reset > jump > branch > stall > normal.
REQ-024 Jump target SHALL be {pc_plus4[31:28], jump_index, 2'b00}, using the IF/ID pc_plus4.
REQ-025 On a redirect in any state:
- pc<=target, valid<=0, skid buffer discarded, state<=REQ.
- Any imem_ready response in the same cycle SHALL be discarded.
- The redirect SHALL override stall.
REQ-026 A redirect SHALL cost exactly one bubble: the first instruction at the target SHALL appear one cycle after the target request is accepted.
REQ-027 opcode SHALL be combinational from instr[31:26].
REQ-028 Throughput SHALL be one instruction per cycle when imem_ready=1 continuously and stall=0.
REQ-029 Fetch latency SHALL be one cycle from the imem_ready accept to the instr/valid update.

Reset
REQ-030 While reset=1 at a clock edge:
- pc<=RESET_PC, state<=IDLE.
- instr<=0, pc_plus4<=0, valid<=0.
- Skid buffer cleared.
- imem_req=0, imem_addr=RESET_PC.
REQ-031 Reset asserted mid-transaction SHALL discard the pending fetch and any skid-buffered word.
REQ-032 After reset deasserts, the first imem_req SHALL occur one cycle later, in IDLE->REQ.

Verification
REQ-033 Reset then imem_ready held at 1 with words 0x2001_0005, 0x0022_1820 -> imem_addr sequence 0, 4, 8; valid rises 2 cycles after reset release; opcode=6'b001000 then 6'b000000.
REQ-034 Stall asserted for 3 cycles while imem_ready=1 -> state HOLD, instr/pc_plus4 frozen, imem_req=0; after release the skid word appears with no instruction lost or duplicated.
REQ-035 Jump with pc_plus4=0x0000_0010 and jump_index=26'h000_0040 -> next imem_addr=0x0000_0100, valid=0 for one cycle.
REQ-036 Branch and stall both asserted with branch_target=0x0000_0200 -> imem_addr=0x200, valid=0; the stale response is dropped.
REQ-037 imem_ready low for 2 cycles -> valid=0 both cycles and imem_addr held constant.
REQ-038 PC starting at 0xFFFF_FFFC -> next imem_addr wraps to 0x0000_0000.
